// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD bus responder:
// FSM states, instruction opcode masks/values and the DDRAM fill character.
package lcd_pkg;

   typedef enum logic [1:0] {
      INIT_FILL,
      IDLE,
      BUSY_WAIT,
      CLEAR_FILL
   } lcd_state_e;

   localparam logic [7:0] ASCII_SPACE  = 8'h20;

   localparam logic [7:0] CLEAR_MASK   = 8'hFF;
   localparam logic [7:0] CLEAR_VAL    = 8'h01;
   localparam logic [7:0] HOME_MASK    = 8'hFE;
   localparam logic [7:0] HOME_VAL     = 8'h02;
   localparam logic [7:0] ENTRY_MASK   = 8'hFC;
   localparam logic [7:0] ENTRY_VAL    = 8'h04;
   localparam logic [7:0] DISPCTL_MASK = 8'hF8;
   localparam logic [7:0] DISPCTL_VAL  = 8'h08;
   localparam logic [7:0] SHIFT_MASK   = 8'hF0;
   localparam logic [7:0] SHIFT_VAL    = 8'h10;
   localparam logic [7:0] FUNCSET_MASK = 8'hE0;
   localparam logic [7:0] FUNCSET_VAL  = 8'h20;
   localparam logic [7:0] SETCG_MASK   = 8'hC0;
   localparam logic [7:0] SETCG_VAL    = 8'h40;
   localparam logic [7:0] SETDD_MASK   = 8'h80;
   localparam logic [7:0] SETDD_VAL    = 8'h80;

   function automatic logic op_match(input logic [7:0] dat,
                                     input logic [7:0] mask,
                                     input logic [7:0] val);
      return (dat & mask) == val;
   endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// 8-bit parallel LCD bus: driver (master) toward the controller model (slave).
interface lcd_bus_responder_if;

   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;
   logic [7:0] lcd_dat_in;
   logic [7:0] lcd_dat_out;
   logic       lcd_dat_oe;

   modport master (
      output lcd_rs, lcd_rw, lcd_en, lcd_dat_in,
      input  lcd_dat_out, lcd_dat_oe
   );

   modport slave (
      input  lcd_rs, lcd_rw, lcd_en, lcd_dat_in,
      output lcd_dat_out, lcd_dat_oe
   );

endinterface

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the LCD bus plus rise/fall pulses on the synced en.
module lcd_bus_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rs,
   input  logic       rw,
   input  logic       en,
   input  logic [7:0] dat,
   output logic       rs_s,
   output logic       rw_s,
   output logic       en_s,
   output logic [7:0] dat_s,
   output logic       en_rise,
   output logic       en_fall
);

   logic       en_p0, en_p1, en_p2;
   logic       rs_p0, rs_p1;
   logic       rw_p0, rw_p1;
   logic [7:0] dat_p0, dat_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_p0 <= 1'b0;
         en_p1 <= 1'b0;
         en_p2 <= 1'b0;
      end else begin
         en_p0 <= en;
         en_p1 <= en_p0;
         en_p2 <= en_p1;
      end
   end

   // rs/rw/dat travel through the same two stages as en so a commit sees a coherent transfer
   always_ff @(posedge clk) begin
      rs_p0  <= rs;
      rw_p0  <= rw;
      dat_p0 <= dat;
      rs_p1  <= rs_p0;
      rw_p1  <= rw_p0;
      dat_p1 <= dat_p0;
   end

   assign rs_s    = rs_p1;
   assign rw_s    = rw_p1;
   assign en_s    = en_p1;
   assign dat_s   = dat_p1;
   assign en_rise = en_p1 & ~en_p2;
   assign en_fall = ~en_p1 & en_p2;

endmodule

// File: rtl/lcd_bus_responder.sv
// Character-LCD controller model: latches bus transfers on falling en, decodes
// the basic instruction set and holds a 64-byte DDRAM with a host read port.
module lcd_bus_responder
   import lcd_pkg::*;
#(
   parameter int DEPTH_LOG2   = 6,
   parameter int BUSY_CYCLES  = 64,
   parameter int CLEAR_CYCLES = 1600
) (
   input  logic                  clk,
   input  logic                  rst_n,
   lcd_bus_responder_if.slave    bus,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [7:0]            rd_data,
   output logic [DEPTH_LOG2-1:0] ac,
   output logic                  busy,
   output logic                  disp_on,
   output logic                  cursor_on,
   output logic                  blink_on,
   output logic                  overrun,
   input  logic                  clr_overrun
);

   localparam int DEPTH   = 1 << DEPTH_LOG2;
   localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef logic [DEPTH_LOG2-1:0] addr_t;

   function automatic addr_t ac_step(input addr_t a, input logic inc);
      return inc ? addr_t'(a + 1'b1) : addr_t'(a - 1'b1);
   endfunction

   logic       rs_s, rw_s, en_s, en_rise, en_fall;
   logic [7:0] dat_s;

   lcd_bus_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .rs      (bus.lcd_rs),
      .rw      (bus.lcd_rw),
      .en      (bus.lcd_en),
      .dat     (bus.lcd_dat_in),
      .rs_s    (rs_s),
      .rw_s    (rw_s),
      .en_s    (en_s),
      .dat_s   (dat_s),
      .en_rise (en_rise),
      .en_fall (en_fall)
   );

   lcd_state_e state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   addr_t      ptr, ptr_nxt, ac_q, ac_nxt;
   logic       id_q, id_nxt, d_q, d_nxt, c_q, c_nxt, b_q, b_nxt;
   logic       ovr_q, ovr_nxt, open_q, open_nxt;
   logic       commit, we;
   addr_t      waddr;
   logic [7:0] wdata;
   logic [7:0] mem [DEPTH];

   // A fall only commits if its rise was seen, so a strobe cut by reset is ignored
   assign commit = en_fall & open_q;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ptr_nxt   = ptr;
      ac_nxt    = ac_q;
      id_nxt    = id_q;
      d_nxt     = d_q;
      c_nxt     = c_q;
      b_nxt     = b_q;
      ovr_nxt   = ovr_q;
      open_nxt  = open_q;
      we        = 1'b0;
      waddr     = ptr;
      wdata     = ASCII_SPACE;

      if (en_rise)      open_nxt = 1'b1;
      else if (en_fall) open_nxt = 1'b0;

      if (clr_overrun) ovr_nxt = 1'b0;

      case (state)
         INIT_FILL, CLEAR_FILL: begin
            we      = 1'b1;
            ptr_nxt = addr_t'(ptr + 1'b1);
            cnt_nxt = CNT_W'(CLEAR_CYCLES - 1);
            if (ptr == addr_t'(DEPTH - 1))
               state_nxt = (state == INIT_FILL) ? IDLE : BUSY_WAIT;
         end
         BUSY_WAIT: begin
            if (cnt == '0) state_nxt = IDLE;
            else           cnt_nxt   = cnt - 1'b1;
         end
         IDLE: begin
            if (commit && !rw_s) begin
               state_nxt = BUSY_WAIT;
               cnt_nxt   = CNT_W'(BUSY_CYCLES);
               if (rs_s) begin
                  we     = 1'b1;
                  waddr  = ac_q;
                  wdata  = dat_s;
                  ac_nxt = ac_step(ac_q, id_q);
               end else if (op_match(dat_s, SETDD_MASK, SETDD_VAL)) begin
                  ac_nxt = dat_s[DEPTH_LOG2-1:0];
               end else if (op_match(dat_s, SETCG_MASK, SETCG_VAL) ||
                            op_match(dat_s, FUNCSET_MASK, FUNCSET_VAL)) begin
                  ac_nxt = ac_q;
               end else if (op_match(dat_s, SHIFT_MASK, SHIFT_VAL)) begin
                  if (!dat_s[3]) ac_nxt = ac_step(ac_q, dat_s[2]);
               end else if (op_match(dat_s, DISPCTL_MASK, DISPCTL_VAL)) begin
                  d_nxt = dat_s[2];
                  c_nxt = dat_s[1];
                  b_nxt = dat_s[0];
               end else if (op_match(dat_s, ENTRY_MASK, ENTRY_VAL)) begin
                  id_nxt = dat_s[1];
               end else if (op_match(dat_s, HOME_MASK, HOME_VAL)) begin
                  ac_nxt = '0;
               end else if (op_match(dat_s, CLEAR_MASK, CLEAR_VAL)) begin
                  ac_nxt    = '0;
                  id_nxt    = 1'b1;
                  ptr_nxt   = '0;
                  state_nxt = CLEAR_FILL;
               end
            end
         end
         default: state_nxt = INIT_FILL;
      endcase

      // Writes while busy are dropped; a new overrun beats a same-cycle clear
      if (commit && !rw_s && state != IDLE) ovr_nxt = 1'b1;
      if (commit && rw_s && rs_s)           ac_nxt  = ac_step(ac_q, id_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= INIT_FILL;
         cnt    <= '0;
         ptr    <= '0;
         ac_q   <= '0;
         id_q   <= 1'b1;
         d_q    <= 1'b0;
         c_q    <= 1'b0;
         b_q    <= 1'b0;
         ovr_q  <= 1'b0;
         open_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         ptr    <= ptr_nxt;
         ac_q   <= ac_nxt;
         id_q   <= id_nxt;
         d_q    <= d_nxt;
         c_q    <= c_nxt;
         b_q    <= b_nxt;
         ovr_q  <= ovr_nxt;
         open_q <= open_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Host port reads the pre-write contents on a same-cycle write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data <= 8'h00;
      else        rd_data <= mem[rd_addr];
   end

   assign busy            = (state != IDLE);
   assign ac              = ac_q;
   assign disp_on         = d_q;
   assign cursor_on       = c_q;
   assign blink_on        = b_q;
   assign overrun         = ovr_q;
   assign bus.lcd_dat_oe  = en_s & rw_s;
   assign bus.lcd_dat_out = !(en_s & rw_s) ? 8'h00 :
                            rs_s ? mem[ac_q] : {busy, 7'(ac_q)};

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: reset/init fill, instruction decode,
// wrap-around, clear with overrun, bus reads and reset during a clear.
module tb_lcd_bus_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] rd_addr;
   logic [7:0] rd_data;
   logic [5:0] ac;
   logic       busy, disp_on, cursor_on, blink_on, overrun, clr_overrun;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   lcd_bus_responder_if bus ();

   lcd_bus_responder #(
      .DEPTH_LOG2   (6),
      .BUSY_CYCLES  (64),
      .CLEAR_CYCLES (1600)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .ac          (ac),
      .busy        (busy),
      .disp_on     (disp_on),
      .cursor_on   (cursor_on),
      .blink_on    (blink_on),
      .overrun     (overrun),
      .clr_overrun (clr_overrun)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Full strobe; returns on the first sample after the commit edge
   task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
      @(negedge clk);
      bus.lcd_rs = rs;
      bus.lcd_rw = rw;
      bus.lcd_dat_in = d;
      bus.lcd_en = 1'b1;
      repeat (4) @(negedge clk);
      bus.lcd_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_idle(input string tag, output int n);
      n = 0;
      while (busy && n < 5000) begin
         n++;
         @(negedge clk);
      end
      if (busy) chk({tag, "_timeout"}, busy, 1'b0);
   endtask

   task automatic wr(input logic rs, input logic [7:0] d);
      int n;
      wait_idle("pre_wr", n);
      strobe(rs, 1'b0, d);
   endtask

   task automatic bus_read(input logic rs, output logic [7:0] dout,
                           output logic oe_hi, output logic oe_lo);
      @(negedge clk);
      bus.lcd_rs = rs;
      bus.lcd_rw = 1'b1;
      bus.lcd_en = 1'b1;
      repeat (2) @(negedge clk);
      dout  = bus.lcd_dat_out;
      oe_hi = bus.lcd_dat_oe;
      repeat (2) @(negedge clk);
      bus.lcd_en = 1'b0;
      repeat (3) @(negedge clk);
      oe_lo = bus.lcd_dat_oe;
      bus.lcd_rw = 1'b0;
   endtask

   task automatic host_rd(input logic [5:0] a, output logic [7:0] d);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      d = rd_data;
   endtask

   task automatic chk_all_space(input string tag);
      logic [7:0] d;
      for (int i = 0; i < 64; i++) begin
         host_rd(6'(i), d);
         chk($sformatf("%s[%0d]", tag, i), d, 8'h20);
      end
   endtask

   initial begin
      int         n;
      int         c0;
      logic [7:0] d;
      logic       hi, lo;

      bus.lcd_rs = 1'b0;
      bus.lcd_rw = 1'b0;
      bus.lcd_en = 1'b0;
      bus.lcd_dat_in = 8'h00;
      rd_addr = '0;
      clr_overrun = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b1);
      chk("rst_ac", ac, 6'd0);
      chk("rst_dcb", {disp_on, cursor_on, blink_on}, 3'b000);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_oe", bus.lcd_dat_oe, 1'b0);
      chk("rst_dout", bus.lcd_dat_out, 8'h00);
      chk("rst_rd_data", rd_data, 8'h00);

      rst_n = 1'b1;
      wait_idle("init", n);
      chk("init_busy_cycles", n, 64);
      chk_all_space("init_ddram");
      chk("init_ac", ac, 6'd0);

      strobe(1'b0, 1'b0, 8'h0C);
      wait_idle("w0c", n);
      chk("write_busy_cycles", n, 65);
      wr(1'b0, 8'h06);
      wr(1'b0, 8'h80);
      wr(1'b1, 8'h30);
      wr(1'b1, 8'h31);
      chk("dispctl_dcb", {disp_on, cursor_on, blink_on}, 3'b100);
      chk("data_ac", ac, 6'd2);
      host_rd(6'd0, d);
      chk("ddram0", d, 8'h30);
      host_rd(6'd1, d);
      chk("ddram1", d, 8'h31);

      wr(1'b0, 8'h14);
      chk("shift_right", ac, 6'd3);
      wr(1'b0, 8'h18);
      chk("shift_display_ignored", ac, 6'd3);
      wr(1'b0, 8'h10);
      chk("shift_left", ac, 6'd2);

      wr(1'b0, 8'hBF);
      chk("setdd_63", ac, 6'd63);
      wr(1'b1, 8'h41);
      chk("wrap_up_ac", ac, 6'd0);
      host_rd(6'd63, d);
      chk("ddram63", d, 8'h41);
      wr(1'b0, 8'h04);
      wr(1'b1, 8'h42);
      chk("wrap_down_ac", ac, 6'd63);
      host_rd(6'd0, d);
      chk("ddram0_dec", d, 8'h42);

      wr(1'b0, 8'h06);
      wr(1'b0, 8'h85);
      bus_read(1'b0, d, hi, lo);
      chk("status_dout", d, 8'h85);
      chk("status_oe_high", hi, 1'b1);
      chk("status_oe_drop", lo, 1'b0);

      wr(1'b0, 8'h81);
      wait_idle("pre_rd", n);
      bus_read(1'b1, d, hi, lo);
      chk("data_rd_dout", d, 8'h31);
      chk("data_rd_oe", hi, 1'b1);
      chk("data_rd_ac", ac, 6'd2);

      wr(1'b0, 8'h04);
      wr(1'b0, 8'h01);
      c0 = cyc;
      strobe(1'b1, 1'b0, 8'h55);
      chk("overrun_set", overrun, 1'b1);
      chk("overrun_ac_unchanged", ac, 6'd0);
      @(negedge clk);
      clr_overrun = 1'b1;
      @(negedge clk);
      chk("overrun_cleared", overrun, 1'b0);
      strobe(1'b1, 1'b0, 8'h56);
      chk("overrun_set_wins", overrun, 1'b1);
      clr_overrun = 1'b0;
      wait_idle("clear", n);
      chk("clear_busy_cycles", cyc - c0, 1664);
      chk_all_space("clear_ddram");
      chk("clear_ac", ac, 6'd0);
      wr(1'b1, 8'h33);
      chk("clear_restores_inc", ac, 6'd1);
      host_rd(6'd0, d);
      chk("post_clear_ddram0", d, 8'h33);

      wr(1'b0, 8'h01);
      repeat (5) @(negedge clk);
      strobe(1'b1, 1'b0, 8'h77);
      bus_read(1'b1, d, hi, lo);
      chk("pre_rst_ac", ac, 6'd1);
      chk("pre_rst_overrun", overrun, 1'b1);
      chk("pre_rst_rd_data", rd_data, 8'h20);
      chk("pre_rst_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ac", ac, 6'd0);
      chk("midrst_dcb", {disp_on, cursor_on, blink_on}, 3'b000);
      chk("midrst_overrun", overrun, 1'b0);
      chk("midrst_rd_data", rd_data, 8'h00);
      chk("midrst_oe", bus.lcd_dat_oe, 1'b0);
      chk("midrst_busy", busy, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      wait_idle("reinit", n);
      chk("reinit_busy_cycles", n, 64);
      chk("reinit_ac", ac, 6'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

Clocked model of the character-LCD controller side of the 8-bit parallel bus (rs/rw/en/dat) that our LCD driver writes to. It samples the bus, latches each transfer on the falling edge of `en`, and decodes the basic instruction set: clear, home, entry mode, display control, cursor shift, and set DDRAM address. It also accepts data writes into a 64-byte DDRAM, answers busy-flag/address and data reads, and exposes a host read port so the display buffer can be inspected in simulation and mirrored on-chip.

## Interface
- `DEPTH_LOG2`, 6, DDRAM address width (64 characters)
- `BUSY_CYCLES`, 64, busy duration after any accepted instruction/data write
- `CLEAR_CYCLES`, 1600, busy duration after a clear completes its fill
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `lcd_rs`  in  1  0 = instruction/status, 1 = data
- `lcd_rw`  in  1  0 = write, 1 = read
- `lcd_en`  in  1  strobe; transfer latched on falling edge
- `lcd_dat_in`  in  8  bus data from driver
- `lcd_dat_out`  out  8  read data toward driver
- `lcd_dat_oe`  out  1  high while a read strobe is active
- `rd_addr`  in  DEPTH_LOG2  host DDRAM read address
- `rd_data`  out  8  DDRAM[rd_addr], 1-cycle latency
- `ac`  out  DEPTH_LOG2  address counter
- `busy`  out  1  busy flag
- `disp_on`, `cursor_on`, `blink_on`  out  1 each  display control bits D/C/B
- `overrun`  out  1  sticky: a write arrived while busy
- `clr_overrun`  in  1  clears `overrun`

## Operation
- Reset values:
  - `ac`=0, `busy`=1, `disp_on`/`cursor_on`/`blink_on`=0, `overrun`=0
  - `lcd_dat_out`=0, `lcd_dat_oe`=0, `rd_data`=0
  - increment mode I/D=1; state INIT_FILL with fill pointer 0
- Bus sync: `lcd_rs`, `lcd_rw`, `lcd_en` and `lcd_dat_in` pass together through 2 flops. A falling edge of the synced `en` commits the transfer using the rs/rw/dat values synced alongside it.
- States:
  - INIT_FILL / CLEAR_FILL: writes 0x20 to DDRAM[ptr], one location per cycle, ptr 0→DEPTH-1.
    - INIT_FILL → IDLE.
    - CLEAR_FILL → BUSY_WAIT(CLEAR_CYCLES).
  - BUSY_WAIT: down-counter; at 0 → IDLE, `busy`=0.
  - IDLE: `busy`=0. Any committed write → BUSY_WAIT(BUSY_CYCLES), except clear → CLEAR_FILL.
- Instruction decode (rs=0, rw=0), highest set bit wins:
  - 1xxxxxxx: set address; `ac`=dat[DEPTH_LOG2-1:0]
  - 01xxxxxx: set CGRAM address; no state change
  - 001xxxxx: function set; no state change
  - 0001SRxx: with S=0, `ac`±1 per R (1 = +1); with S=1, ignored
  - 00001DCB: display control; load D/C/B
  - 000001Ix: entry mode; load I/D (shift bit ignored)
  - 0000001x: home; `ac`=0
  - 00000001: clear; `ac`=0, I/D=1, enter CLEAR_FILL
- Data write (rs=1, rw=0): DDRAM[`ac`]=dat, then `ac` steps per I/D.
- Reads (rw=1):
  - While synced `en` is high, `lcd_dat_oe`=1.
  - rs=0: `lcd_dat_out`={`busy`, 0, `ac`}.
  - rs=1: `lcd_dat_out`=DDRAM[`ac`]; on commit, `ac` steps per I/D.
  - Reads are legal while busy.
- `ac` wraps modulo DEPTH in both directions: 63+1→0, 0−1→63.
- Write while `busy`=1: dropped with no state change, `overrun`=1.
- `clr_overrun` in the same cycle as a new overrun: set wins.
- Host read port is read-first: same-cycle write to `rd_addr` returns the old byte.

## Timing
- Commit happens 3 `clk` edges after `lcd_en` falls at the pin. `ac`, control bits and `busy` update on that edge.
- `busy` rises on the commit edge.
  - Ordinary write: `busy` stays high for BUSY_CYCLES+1 cycles.
  - Clear: `busy` stays high for DEPTH fill cycles + CLEAR_CYCLES.
- `lcd_dat_oe` and `lcd_dat_out` are valid 2 edges after `lcd_en` rises; `lcd_dat_oe` drops 2 edges after `lcd_en` falls.
- The driver must hold `en` high and low for at least 3 `clk` each; shorter pulses are undefined.
- `rd_data` valid 1 edge after `rd_addr`.
- Reset assertion mid-operation aborts any fill/wait immediately. Release always restarts INIT_FILL, with `busy`=1 for DEPTH cycles.

## Structure
- Package `lcd_pkg` holds:
  - instruction opcode masks/values (CLEAR, HOME, ENTRY, DISPCTL, SHIFT, FUNCSET, SETCG, SETDD)
  - state enum {INIT_FILL, IDLE, BUSY_WAIT, CLEAR_FILL}
  - ASCII_SPACE = 8'h20
- Sub-module `lcd_bus_sync`: 2-flop synchronizer for rs/rw/en/dat plus `en` rise/fall pulse generation.
- DDRAM is an inferred 64×8 RAM with one write port and two read ports (bus, host); it is not reset.

## Test plan
- Release reset → `busy`=1 for 64 cycles then 0; every host read returns 0x20; `ac`=0.
- Write 0x0C, 0x06, 0x80, then data "0","1" (0x30, 0x31) → D=1, C=0, B=0; DDRAM[0]=0x30, DDRAM[1]=0x31; `ac`=2.
- Write 0x80|63, then data 0x41 → DDRAM[63]=0x41, `ac`=0. Entry 0x04, then data 0x42 → DDRAM[0]=0x42, `ac`=63.
- Write 0x01 after filling data → `busy` high for 64+1600 cycles; all locations 0x20; `ac`=0. A data write during that window is dropped and `overrun`=1; `clr_overrun` clears it.
- Status read with rs=0, rw=1 mid-busy with `ac`=5 → `lcd_dat_out`=0x85 and `lcd_dat_oe`=1 while `en` is high. Data read at `ac`=1 → 0x31, then `ac`=2.
- Assert `rst_n` in the middle of CLEAR_FILL → all outputs go to reset values immediately; INIT_FILL then completes in 64 cycles.
